// File: rtl/command_sequencer.sv
// Command sequencer: buffers host commands in a FIFO and issues them
// one at a time as a held command bus plus a one-cycle syscall pulse.
module command_sequencer #(
  parameter int DEPTH    = 8,
  parameter int CMD_W    = 12,
  parameter int OP_GAP   = 1,
  parameter int CAS_WAIT = 2,
  parameter int CNT_W    = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [CMD_W-1:0]         cmd_in,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     run_en,
  input  logic                     flush,
  output logic [CMD_W-1:0]         command,
  output logic                     syscall,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [CNT_W-1:0]         issued_cnt
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = AW + 1;
  localparam int GMAX = (CAS_WAIT > OP_GAP) ? CAS_WAIT : OP_GAP;
  localparam int WW   = $clog2(GMAX + 1);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  logic [CMD_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [CW-1:0]    r_count;
  state_t           r_state;
  logic [WW-1:0]    r_wait;
  logic [CMD_W-1:0] r_command;
  logic             r_syscall;
  logic [CNT_W-1:0] r_issued;

  logic             w_ready;
  logic             w_push;
  logic             w_pop;
  logic [CMD_W-1:0] w_head;
  logic             w_cas;

  assign w_ready = (r_count != CW'(DEPTH));
  assign w_push  = cmd_valid && w_ready && !flush;
  assign w_pop   = (r_state == S_IDLE) && (r_count != '0)
                   && run_en && !flush;
  assign w_head  = r_mem[r_rd];
  assign w_cas   = (w_head[CMD_W-1 -: 3] == 3'b111);

  // Storage needs no reset: only entries below count are ever read.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= cmd_in;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_wait    <= '0;
      r_command <= '0;
      r_syscall <= 1'b0;
      r_issued  <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_syscall <= 1'b0;
          if (w_pop) begin
            r_command <= w_head;
            r_syscall <= 1'b1;
            r_issued  <= r_issued + CNT_W'(1);
            r_wait    <= w_cas ? WW'(CAS_WAIT) : WW'(OP_GAP);
            r_state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          r_syscall <= 1'b0;
          if (r_wait == WW'(1)) r_state <= S_IDLE;
          else                  r_wait  <= r_wait - WW'(1);
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready  = w_ready;
  assign command    = r_command;
  assign syscall    = r_syscall;
  assign busy       = (r_state == S_WAIT) || (r_count != '0);
  assign fifo_count = r_count;
  assign issued_cnt = r_issued;

endmodule

// File: tb/tb_command_sequencer.sv
// Directed bench for command_sequencer: reset, issue latency, spacing,
// back-pressure, flush and reset during WAIT.
module tb_command_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] cmd_in;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        run_en;
  logic        flush;
  logic [11:0] command;
  logic        syscall;
  logic        busy;
  logic [3:0]  fifo_count;
  logic [15:0] issued_cnt;

  int n_vec = 0;
  int n_err = 0;

  command_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_in     (cmd_in),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .run_en     (run_en),
    .flush      (flush),
    .command    (command),
    .syscall    (syscall),
    .busy       (busy),
    .fifo_count (fifo_count),
    .issued_cnt (issued_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [11:0] seq_cmd [3];
  logic [7:0]  seq_sc;
  int          seq_k;

  initial begin
    seq_cmd[0] = 12'h2C5;
    seq_cmd[1] = 12'hE50;
    seq_cmd[2] = 12'h1FF;
    seq_sc     = 8'b0100_1010;
    seq_k      = 0;

    rst_n     = 1'b0;
    cmd_valid = 1'b1;
    cmd_in    = 12'h123;
    run_en    = 1'b1;
    flush     = 1'b0;
    repeat (3) tick();
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_sys", 32'(syscall), 32'd0);
    chk("rst_cmd", 32'(command), 32'd0);
    chk("rst_issued", 32'(issued_cnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    cmd_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // Single issue
    cmd_in = 12'h0A3; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    chk("one_count", 32'(fifo_count), 32'd1);
    chk("one_nobypass", 32'(syscall), 32'd0);
    tick();
    chk("one_sys", 32'(syscall), 32'd1);
    chk("one_cmd", 32'(command), 32'h0A3);
    chk("one_issued", 32'(issued_cnt), 32'd1);
    chk("one_busy", 32'(busy), 32'd1);
    chk("one_pop", 32'(fifo_count), 32'd0);
    tick();
    chk("one_pulse", 32'(syscall), 32'd0);
    chk("one_hold", 32'(command), 32'h0A3);
    tick();
    chk("one_idle", 32'(busy), 32'd0);

    // Spacing: rises expected at a+1, a+3, a+6
    for (int i = 0; i < 8; i++) begin
      if (i < 3) begin
        cmd_in = seq_cmd[i]; cmd_valid = 1'b1;
      end else begin
        cmd_valid = 1'b0;
      end
      tick();
      chk($sformatf("gap_sys%0d", i), 32'(syscall), 32'(seq_sc[i]));
      if (seq_sc[i]) begin
        chk($sformatf("gap_cmd%0d", i), 32'(command), 32'(seq_cmd[seq_k]));
        seq_k++;
      end
    end
    chk("gap_issued", 32'(issued_cnt), 32'd4);

    // Back-pressure with run_en low
    run_en = 1'b0;
    for (int i = 0; i < 9; i++) begin
      cmd_in = 12'h100 + 12'(i); cmd_valid = 1'b1;
      tick();
      if (i == 7) chk("full_ready", 32'(cmd_ready), 32'd0);
    end
    chk("full_count", 32'(fifo_count), 32'd8);
    chk("full_nosys", 32'(syscall), 32'd0);
    run_en = 1'b1;
    tick();
    chk("bp_sys", 32'(syscall), 32'd1);
    chk("bp_cmd", 32'(command), 32'h100);
    chk("bp_count", 32'(fifo_count), 32'd7);
    tick();
    cmd_valid = 1'b0;
    chk("bp_accept", 32'(fifo_count), 32'd8);
    chk("bp_ready", 32'(cmd_ready), 32'd0);
    tick();
    chk("bp_cmd2", 32'(command), 32'h101);
    chk("bp_sys2", 32'(syscall), 32'd1);
    run_en = 1'b0;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("bp_flush", 32'(fifo_count), 32'd0);
    chk("bp_issued", 32'(issued_cnt), 32'd6);

    // Flush during a CAS WAIT
    for (int i = 0; i < 4; i++) begin
      cmd_in = (i == 0) ? 12'hE01 : 12'h200 + 12'(i); cmd_valid = 1'b1;
      tick();
    end
    cmd_valid = 1'b0;
    chk("fl_fill", 32'(fifo_count), 32'd4);
    run_en = 1'b1;
    tick();
    chk("fl_issue", 32'(command), 32'hE01);
    flush = 1'b1; cmd_valid = 1'b1; cmd_in = 12'h3AA;
    tick();
    flush = 1'b0; cmd_valid = 1'b0;
    chk("fl_count", 32'(fifo_count), 32'd0);
    chk("fl_cmd", 32'(command), 32'hE01);
    chk("fl_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("fl_nosys%0d", i), 32'(syscall), 32'd0);
    end
    chk("fl_issued", 32'(issued_cnt), 32'd7);
    chk("fl_idle", 32'(busy), 32'd0);

    // Reset in the first WAIT cycle of a CAS
    cmd_in = 12'hE22; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("rw_sys", 32'(syscall), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rw_sys0", 32'(syscall), 32'd0);
    chk("rw_issued", 32'(issued_cnt), 32'd0);
    chk("rw_count", 32'(fifo_count), 32'd0);
    chk("rw_busy", 32'(busy), 32'd0);
    chk("rw_cmd", 32'(command), 32'd0);
    cmd_in = 12'h0C3; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    chk("rw_lat0", 32'(syscall), 32'd0);
    tick();
    chk("rw_lat1", 32'(syscall), 32'd1);
    chk("rw_cmd2", 32'(command), 32'h0C3);
    chk("rw_issued2", 32'(issued_cnt), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
